// File: rtl/tlb_assoc_refill.sv
// Fully associative TLB with hardware refill from the page-table walker,
// round-robin victim replacement and global flush. Optional perf counters: TLB_PERF_CNT_EN.
module tlb_assoc_refill #(
   parameter int unsigned ENTRIES  = 32,
   parameter int unsigned VPN_W    = 20,
   parameter int unsigned PPN_W    = 20,
   parameter int unsigned OFFSET_W = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      lk_valid,
   output logic                      lk_ready,
   input  logic [VPN_W+OFFSET_W-1:0] lk_vaddr,
   input  logic                      lk_write,
   output logic                      rsp_valid,
   output logic                      rsp_hit,
   output logic                      rsp_fault,
   output logic [PPN_W+OFFSET_W-1:0] rsp_paddr,
   output logic                      dirty_evt,
   output logic                      ptw_req,
   output logic [VPN_W-1:0]          ptw_vpn,
   input  logic                      ptw_ack,
   input  logic                      ptw_present,
   input  logic [PPN_W-1:0]          ptw_ppn,
   input  logic                      flush,
   output logic [31:0]               hit_cnt,
   output logic [31:0]               miss_cnt
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int          NENT  = ENTRIES;

   typedef enum logic [1:0] {StIdle, StCheck, StWalk, StResp} state_e;

   state_e                    r_state;
   state_e                    w_state_d;

   logic [VPN_W+OFFSET_W-1:0] r_vaddr;
   logic                      r_write;
   logic [ENTRIES-1:0]        r_valid;
   logic [ENTRIES-1:0]        r_dirty;
   logic [VPN_W-1:0]          r_vpn [ENTRIES];
   logic [PPN_W-1:0]          r_ppn [ENTRIES];
   logic [IDX_W-1:0]          r_rr_ptr;
   logic                      r_flush_pend;
   logic                      r_rsp_hit;
   logic                      r_rsp_fault;
   logic [PPN_W+OFFSET_W-1:0] r_rsp_paddr;
   logic                      r_dirty_evt;

   logic [VPN_W-1:0]          w_vpn;
   logic [OFFSET_W-1:0]       w_offset;
   logic                      w_hit;
   logic [IDX_W-1:0]          w_hit_idx;
   logic                      w_has_free;
   logic [IDX_W-1:0]          w_free_idx;
   logic [IDX_W-1:0]          w_victim;
   logic                      w_accept;
   logic                      w_apply_flush;
   logic                      w_check_hit;
   logic                      w_check_miss;
   logic                      w_walk_done;
   logic                      w_install;
   logic                      w_set_dirty;

   assign w_vpn    = r_vaddr[VPN_W+OFFSET_W-1:OFFSET_W];
   assign w_offset = r_vaddr[OFFSET_W-1:0];

   // Refills never duplicate a VPN, so at most one entry can match.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = 0; i < NENT; i++) begin
         if (r_valid[i] && (r_vpn[i] == w_vpn)) begin
            w_hit     = 1'b1;
            w_hit_idx = IDX_W'(i);
         end
      end
   end

   // Scan downward so the lowest-index invalid entry wins.
   always_comb begin
      w_has_free = 1'b0;
      w_free_idx = '0;
      for (int i = NENT - 1; i >= 0; i--) begin
         if (!r_valid[i]) begin
            w_has_free = 1'b1;
            w_free_idx = IDX_W'(i);
         end
      end
   end

   assign w_victim = w_has_free ? w_free_idx : r_rr_ptr;

   always_comb begin
      w_state_d     = r_state;
      w_accept      = 1'b0;
      w_apply_flush = 1'b0;
      case (r_state)
         StIdle: begin
            if (r_flush_pend) begin
               w_apply_flush = 1'b1;
            end else if (lk_valid) begin
               w_accept  = 1'b1;
               w_state_d = StCheck;
            end
         end
         StCheck: w_state_d = w_hit ? StResp : StWalk;
         StWalk:  if (ptw_ack) w_state_d = StResp;
         StResp:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   assign w_check_hit  = (r_state == StCheck) && w_hit;
   assign w_check_miss = (r_state == StCheck) && !w_hit;
   assign w_walk_done  = (r_state == StWalk) && ptw_ack;
   assign w_install    = w_walk_done && ptw_present;
   assign w_set_dirty  = w_check_hit && r_write && !r_dirty[w_hit_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StIdle;
         r_vaddr      <= '0;
         r_write      <= 1'b0;
         r_flush_pend <= 1'b0;
         r_rr_ptr     <= '0;
         r_rsp_hit    <= 1'b0;
         r_rsp_fault  <= 1'b0;
         r_rsp_paddr  <= '0;
         r_dirty_evt  <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_flush_pend <= flush | (r_flush_pend & ~w_apply_flush);
         r_dirty_evt  <= w_set_dirty;
         if (w_accept) begin
            r_vaddr <= lk_vaddr;
            r_write <= lk_write;
         end
         if (w_check_hit) begin
            r_rsp_hit   <= 1'b1;
            r_rsp_fault <= 1'b0;
            r_rsp_paddr <= {r_ppn[w_hit_idx], w_offset};
         end
         if (w_walk_done) begin
            r_rsp_hit <= 1'b0;
            if (ptw_present) begin
               r_rsp_fault <= 1'b0;
               r_rsp_paddr <= {ptw_ppn, w_offset};
               if (!w_has_free) begin
                  r_rr_ptr <= r_rr_ptr + IDX_W'(1);
               end
            end else begin
               r_rsp_fault <= 1'b1;
               r_rsp_paddr <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_dirty <= '0;
         for (int i = 0; i < NENT; i++) begin
            r_vpn[i] <= '0;
            r_ppn[i] <= '0;
         end
      end else if (w_apply_flush) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else begin
         if (w_set_dirty) begin
            r_dirty[w_hit_idx] <= 1'b1;
         end
         if (w_install) begin
            r_valid[w_victim] <= 1'b1;
            r_dirty[w_victim] <= r_write;
            r_vpn[w_victim]   <= w_vpn;
            r_ppn[w_victim]   <= ptw_ppn;
         end
      end
   end

   assign lk_ready  = (r_state == StIdle) && !r_flush_pend;
   assign ptw_req   = (r_state == StWalk);
   assign ptw_vpn   = w_vpn;
   assign rsp_valid = (r_state == StResp);
   assign rsp_hit   = r_rsp_hit;
   assign rsp_fault = r_rsp_fault;
   assign rsp_paddr = r_rsp_paddr;
   assign dirty_evt = r_dirty_evt;

`ifdef TLB_PERF_CNT_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (w_apply_flush) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_check_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if (w_check_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`else
   logic w_unused_cnt;
   assign w_unused_cnt = w_check_miss;
   assign hit_cnt      = '0;
   assign miss_cnt     = '0;
`endif

endmodule

// File: doc/tlb_assoc_refill.md
Name: tlb_assoc_refill

Overview:
- Parametrised, fully associative TLB. Successor to the fixed 32-entry software-loaded TLB.
- Adds configurable depth and widths, a valid/dirty bit per entry, automatic hardware refill from the page-table walker on a miss, victim replacement and a global flush.
- Sits in the memory stage between the address ALU output and the data-memory port.

Parameters:
- ENTRIES, 32, number of TLB entries (power of 2, at least 2).
- VPN_W, 20, virtual page number width.
- PPN_W, 20, physical page number width.
- OFFSET_W, 12, page offset width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- lk_valid  in  1  lookup request.
- lk_ready  out  1  block can accept a lookup.
- lk_vaddr  in  VPN_W+OFFSET_W  virtual address.
- lk_write  in  1  lookup is a store.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_hit  out  1  translation came from the TLB.
- rsp_fault  out  1  page not present.
- rsp_paddr  out  PPN_W+OFFSET_W  physical address.
- dirty_evt  out  1  one-cycle pulse: first store to a clean page.
- ptw_req  out  1  walk request.
- ptw_vpn  out  VPN_W  VPN to walk.
- ptw_ack  in  1  walk complete.
- ptw_present  in  1  PTE valid.
- ptw_ppn  in  PPN_W  PTE frame number.
- flush  in  1  invalidate-all pulse.
- hit_cnt  out  32  hit counter (optional feature).
- miss_cnt  out  32  miss counter (optional feature).

Behaviour:
- Reset values:
  - FSM in IDLE.
  - All valid and dirty bits 0; all other entry fields 0.
  - Round-robin pointer 0; flush_pend 0.
  - All outputs 0, except lk_ready=1 (IDLE with no flush pending).
- FSM states: IDLE, CHECK, WALK, RESP.
- IDLE:
  - lk_ready = !flush_pend.
  - If flush_pend: clear all valid and dirty bits and flush_pend on the edge; no lookup is accepted in that cycle.
  - Else if lk_valid: register vaddr and write, go to CHECK.
- flush pulse in any state sets flush_pend. The flush is applied in the next IDLE cycle. An in-flight lookup completes against pre-flush contents.
- CHECK: compare the registered VPN against every valid entry. Only refills create entries, so no duplicates exist.
  - Hit:
    - Load rsp_hit=1, rsp_fault=0, rsp_paddr={ppn,offset}.
    - If write and the entry is clean: set dirty and pulse dirty_evt with the response.
    - Go to RESP.
  - Miss: go to WALK with ptw_vpn=VPN.
- WALK:
  - ptw_req=1 and ptw_vpn held stable until ptw_ack is sampled high.
  - On the ack edge, if ptw_present=1:
    - Victim is the lowest-index invalid entry; if none, the round-robin pointer entry, and the pointer increments modulo ENTRIES.
    - Install valid=1, dirty=lk_write, vpn, ppn.
    - Load rsp_hit=0, rsp_fault=0, rsp_paddr={ptw_ppn,offset}.
    - Go to RESP.
  - On the ack edge, if ptw_present=0: no install; rsp_fault=1, rsp_paddr=0; go to RESP.
  - ptw_req deasserts on the same edge.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - rsp_hit, rsp_fault and rsp_paddr hold until the next response.
  - dirty_evt is high only in the RESP cycle.
- Latency: from the acceptance edge, a hit gives rsp_valid 2 cycles later. A miss gives rsp_valid 1 cycle after the ack edge.
- lk_ready=0 in CHECK, WALK and RESP.
- ptw_ack outside WALK is ignored.
- rst mid-walk: ptw_req drops immediately (asynchronous) and all entries are invalidated.

Optional Feature:
- Macro: TLB_PERF_CNT_EN.
- Defined: hit_cnt increments on each CHECK hit; miss_cnt increments on each CHECK miss. Both are 32-bit, saturate at 0xFFFFFFFF, reset to 0 and are cleared by flush.
- Not defined: hit_cnt and miss_cnt are tied to 0 and no counter logic is synthesised; ports remain.

Test Plan:
- Cold miss:
  - Stimulus: lookup 0x12345ABC (VPN_W=20, OFFSET_W=12), walker acks after 3 cycles with ppn=0x00077, present=1.
  - Required: ptw_vpn=0x12345; rsp_valid with hit=0, paddr=0x00077ABC; entry 0 valid.
- Hit and dirty:
  - Stimulus: repeat 0x12345ABC as a store.
  - Required: rsp 2 cycles after acceptance, hit=1, dirty_evt=1.
  - Stimulus: repeat the store again.
  - Required: dirty_evt=0.
- Fault:
  - Stimulus: lookup 0x0000F000, ack with present=0.
  - Required: rsp_fault=1, no entry installed; the same lookup misses again.
- Replacement:
  - Stimulus: fill 32 distinct VPNs, then lookups for VPNs 33 and 34.
  - Required: entries 0 and 1 replaced; the original VPN 0 now misses.
- Flush:
  - Stimulus: pulse flush while in WALK.
  - Required: the walk completes and installs; in the next IDLE cycle lk_ready=0 for one cycle; all prior VPNs then miss.
- Reset mid-walk:
  - Stimulus: assert rst while ptw_req=1.
  - Required: ptw_req=0 immediately, lk_ready=1 after release, and the previously installed VPN misses.
